regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (rd/i_data) between two write-back requesters:
//  ALU result path (A) and memory-load path (B).
//  Keeps a per-register busy scoreboard so decode can stall on RAW hazards for rs/rt.
//  Sits between the multicycle execute/memory stages and the register slices.
// PARAMETERS
//  DW      32   data width of write-back payload
//  AW      5    register address width; NREG = 2**AW
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst          in   1    reset, synchronous, active-high
//  a_valid      in   1    ALU write-back request
//  a_rd         in   AW   ALU destination register
//  a_data       in   DW   ALU result
//  a_ready      out  1    ALU request accepted this cycle (combinational)
//  b_valid      in   1    load write-back request
//  b_rd         in   AW   load destination register
//  b_data       in   DW   load data
//  b_ready      out  1    load request accepted this cycle (combinational)
//  wr_en        out  1    register-file write strobe (registered)
//  wr_addr      out  AW   register-file write address, drives rd (registered)
//  wr_data      out  DW   register-file write data, drives i_data (registered)
//  sb_set_en    in   1    decode issued an instruction writing sb_set_rd
//  sb_set_rd    in   AW   destination to mark busy
//  rs, rt       in   AW   decode source operands to check
//  rs_busy      out  1    scoreboard[rs] (combinational)
//  rt_busy      out  1    scoreboard[rt] (combinational)
//  sb_err       out  1    sticky: set to an already-busy register (WAW issue)
// BEHAVIOUR
//  - Reset: wr_en=0, wr_addr=0, wr_data=0, scoreboard all 0, rr_ptr=A, sb_err=0.
//  - Handshake: transfer when valid && ready; ready is the grant, only one grant per cycle.
//    Requester holds valid/rd/data stable until ready is seen.
//  - Arbitration: only A valid -> A; only B valid -> B; both -> side at rr_ptr.
//    rr_ptr toggles to the loser after each contested grant only; uncontested grants leave it.
//  - Latency: request accepted in cycle N -> wr_en=1, wr_addr=rd, wr_data=data in cycle N+1.
//    wr_en is a 1-cycle pulse per accepted request; back-to-back grants give back-to-back writes.
//  - Register 0: requests with rd=0 are accepted (ready=1) but produce wr_en=0 in N+1.
//    Scoreboard bit 0 is constant 0; sb_set_rd=0 is ignored.
//  - Scoreboard: bit set on the clock edge where sb_set_en=1; cleared on the edge closing the
//    cycle where wr_en=1 for wr_addr. Same register set and cleared in the same cycle: set wins.
//  - sb_err: set when sb_set_en targets a bit already 1 and not cleared that cycle; cleared only by rst.
//  - rs_busy/rt_busy reflect the registered scoreboard only; no lookahead on pending grants.
//  - Reset mid-operation: any in-flight write is dropped (wr_en=0 next cycle); busy bits lost.
// CONFIGURATION
//  REGFILE_WB_FWD_EN defined: extra outputs fwd_a_hit, fwd_b_hit (1b) and fwd_data (DW).
//    fwd_a_hit = wr_en && wr_addr==rs && rs!=0; fwd_b_hit likewise for rt; fwd_data = wr_data.
//    rs_busy/rt_busy are forced 0 when the matching fwd hit is 1 (same-cycle bypass).
//  REGFILE_WB_FWD_EN undefined: ports absent; busy stays 1 until the cycle after wr_en.
// TESTING
//  1. rst=1 for 2 cycles -> wr_en=0, rs_busy=rt_busy=0, sb_err=0, a_ready=b_ready=0 with no valid.
//  2. a_valid, a_rd=5, a_data=32'hDEADBEEF -> a_ready same cycle; next cycle wr_en=1, wr_addr=5, wr_data=DEADBEEF.
//  3. a_valid & b_valid held 4 cycles (rd 3/4) -> grants A,B,A,B; four consecutive wr_en pulses.
//  4. sb_set rd=7; rs=7 -> rs_busy=1; b write rd=7 -> rs_busy=0 the cycle after wr_en (FWD_EN: 0 during it).
//  5. a_valid rd=0 data=1 -> a_ready=1, no wr_en; sb_set rd=0 -> rs=0 rs_busy stays 0.
//  6. sb_set rd=9 twice -> sb_err=1 sticky; rst mid-request -> next cycle wr_en=0, all busy 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU write-back path (A)
// and the memory-load write-back path (B). It also keeps a per-register busy
// scoreboard so that decode can stall on RAW hazards for rs/rt.
//
// Build option: define REGFILE_WB_FWD_EN to add the same-cycle forwarding outputs
// (fwd_a_hit_o, fwd_b_hit_o, fwd_data_o). With this option, rs/rt busy is masked
// while the matching register is being written.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid_i,
    input  logic [AW-1:0] a_rd_i,
    input  logic [DW-1:0] a_data_i,
    output logic          a_ready_o,
    input  logic          b_valid_i,
    input  logic [AW-1:0] b_rd_i,
    input  logic [DW-1:0] b_data_i,
    output logic          b_ready_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o,
    input  logic          sb_set_en_i,
    input  logic [AW-1:0] sb_set_rd_i,
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rt_i,
    output logic          rs_busy_o,
    output logic          rt_busy_o,
`ifdef REGFILE_WB_FWD_EN
    output logic          fwd_a_hit_o,
    output logic          fwd_b_hit_o,
    output logic [DW-1:0] fwd_data_o,
`endif
    output logic          sb_err_o
);

    localparam int NREG = 2 ** AW;

    // Round-robin pointer: names the side that wins the next contested cycle.
    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

    side_e           rr_q, rr_d;
    logic            grant_a_s, grant_b_s;

    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic [NREG-1:0] sb_q, sb_d;
    logic [NREG-1:0] sb_clr_s, sb_set_s;
    logic            sb_err_q, sb_err_d;

    // Arbitration: a single valid side wins outright. A contested cycle goes to rr_q,
    // and the pointer then moves to the loser.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        rr_d      = rr_q;
        if (a_valid_i && b_valid_i) begin
            if (rr_q == SIDE_A) begin
                grant_a_s = 1'b1;
                rr_d      = SIDE_B;
            end else begin
                grant_b_s = 1'b1;
                rr_d      = SIDE_A;
            end
        end else if (a_valid_i) begin
            grant_a_s = 1'b1;
        end else if (b_valid_i) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a_ready_o = grant_a_s;
    assign b_ready_o = grant_b_s;

    // Write-port next state: capture the granted payload. An rd of 0 is accepted
    // but produces no strobe, because r0 is hard-wired.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_a_s) begin
            wr_en_d   = (a_rd_i != {AW{1'b0}});
            wr_addr_d = a_rd_i;
            wr_data_d = a_data_i;
        end else if (grant_b_s) begin
            wr_en_d   = (b_rd_i != {AW{1'b0}});
            wr_addr_d = b_rd_i;
            wr_data_d = b_data_i;
        end else begin
            wr_en_d   = 1'b0;
        end
    end

    // Scoreboard next state: clear on the write strobe, set on issue (set wins).
    // Bit 0 never becomes busy.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sb_clr_s[i] = wr_en_q && (wr_addr_q == AW'(i));
            sb_set_s[i] = sb_set_en_i && (sb_set_rd_i == AW'(i)) && (i != 0);
        end
        sb_d    = (sb_q & ~sb_clr_s) | sb_set_s;
        sb_d[0] = 1'b0;
    end

    // WAW detection: issuing to a register that is still busy and not retiring this
    // cycle. The flag is sticky until reset.
    always_comb begin
        sb_err_d = sb_err_q;
        if (sb_set_en_i && (sb_set_rd_i != {AW{1'b0}}) &&
            sb_q[sb_set_rd_i] && !sb_clr_s[sb_set_rd_i]) begin
            sb_err_d = 1'b1;
        end else begin
            sb_err_d = sb_err_q;
        end
    end

    // State registers. A synchronous reset drops any in-flight write and all busy bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= SIDE_A;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {AW{1'b0}};
            wr_data_q <= {DW{1'b0}};
            sb_q      <= {NREG{1'b0}};
            sb_err_q  <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sb_q      <= sb_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign sb_err_o  = sb_err_q;

`ifdef REGFILE_WB_FWD_EN
    logic fwd_a_hit_s, fwd_b_hit_s;

    assign fwd_a_hit_s = wr_en_q && (wr_addr_q == rs_i) && (rs_i != {AW{1'b0}});
    assign fwd_b_hit_s = wr_en_q && (wr_addr_q == rt_i) && (rt_i != {AW{1'b0}});
    assign fwd_a_hit_o = fwd_a_hit_s;
    assign fwd_b_hit_o = fwd_b_hit_s;
    assign fwd_data_o  = wr_data_q;
    assign rs_busy_o   = sb_q[rs_i] && !fwd_a_hit_s;
    assign rt_busy_o   = sb_q[rt_i] && !fwd_b_hit_s;
`else
    assign rs_busy_o   = sb_q[rs_i];
    assign rt_busy_o   = sb_q[rt_i];
`endif

endmodule
